// File: rtl/ofm_wb_writer_pkg.sv
// Shared CNN datapath constants, derived-size helpers and the write-back FSM state type.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_OUT_SIZE      = 16;
    localparam int DEF_ROWS_PER_WORD = 4;
    localparam int DEF_NUM_CH        = 128;
    localparam int DEF_ADDR_WIDTH    = 9;

    function automatic int word_width(input int dw, input int os, input int rpw);
        return dw * os * rpw;
    endfunction

    function automatic int groups(input int os, input int rpw);
        return os / rpw;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_W = word_width(DEF_DATA_WIDTH, DEF_OUT_SIZE, DEF_ROWS_PER_WORD);
    localparam int DEF_G = groups(DEF_OUT_SIZE, DEF_ROWS_PER_WORD);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/ofm_wb_writer_if.sv
// Feature-map memory write port; the writer is the master, the memory the slave.
interface ofm_wb_writer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 512
);
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_writedata;
    logic                  mem_waitrequest;

    modport master (
        output mem_wr,
        output mem_addr,
        output mem_writedata,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_wr,
        input  mem_addr,
        input  mem_writedata,
        output mem_waitrequest
    );
endinterface

// File: rtl/ofm_wb_writer_row_packer.sv
// Selects memory word 'group' out of a full output map: ROWS_PER_WORD consecutive rows,
// row-interleaved exactly like the ifm read layout, so rows stay contiguous in the word.
module ofm_row_packer
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter  int OUT_SIZE      = DEF_OUT_SIZE,
    parameter  int ROWS_PER_WORD = DEF_ROWS_PER_WORD,
    localparam int WORD_BITS     = word_width(DATA_WIDTH, OUT_SIZE, ROWS_PER_WORD),
    localparam int GROUPS        = groups(OUT_SIZE, ROWS_PER_WORD),
    localparam int GRP_W         = idx_width(GROUPS),
    localparam int MAP_BITS      = DATA_WIDTH * OUT_SIZE * OUT_SIZE
) (
    input  logic [MAP_BITS-1:0]  ofm,
    input  logic [GRP_W-1:0]     group,
    output logic [WORD_BITS-1:0] word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < GROUPS; i++) begin
            if (group == GRP_W'(i)) begin
                word = ofm[i*WORD_BITS +: WORD_BITS];
            end
        end
    end

endmodule

// File: rtl/ofm_wb_writer.sv
// Write-back stage: captures one output channel per in_valid and streams it to feature-map
// memory as G words. Optional statistics counters are enabled by OFM_WB_WRITER_STATS_EN.
module ofm_wb_writer
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter  int OUT_SIZE      = DEF_OUT_SIZE,
    parameter  int ROWS_PER_WORD = DEF_ROWS_PER_WORD,
    parameter  int NUM_CH        = DEF_NUM_CH,
    parameter  int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    localparam int WORD_BITS     = word_width(DATA_WIDTH, OUT_SIZE, ROWS_PER_WORD),
    localparam int GROUPS        = groups(OUT_SIZE, ROWS_PER_WORD),
    localparam int GRP_W         = idx_width(GROUPS),
    localparam int CH_W          = idx_width(NUM_CH),
    localparam int MAP_BITS      = DATA_WIDTH * OUT_SIZE * OUT_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [MAP_BITS-1:0] in_ofm,
    output logic                in_ready,
    ofm_wb_writer_if.master     mem,
    output logic [CH_W-1:0]     channel,
    output logic                layer_done,
    output logic                overflow
`ifdef OFM_WB_WRITER_STATS_EN
    ,
    output logic [31:0]         word_count,
    output logic [31:0]         stall_count
`endif
);

    localparam logic [GRP_W-1:0]      LAST_GRP = GRP_W'(GROUPS - 1);
    localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [ADDR_WIDTH-1:0] GROUPS_A = ADDR_WIDTH'(GROUPS);

    wb_state_e           state;
    wb_state_e           next_state;
    logic [MAP_BITS-1:0] ofm_buf;
    logic [GRP_W-1:0]    grp;
    logic                accept;
    logic                last_word;
    logic                last_channel;

    assign accept       = (state == WRITE) && !mem.mem_waitrequest;
    assign last_word    = (grp == LAST_GRP);
    assign last_channel = (channel == LAST_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem.mem_wr = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = WRITE;
            end
            WRITE: begin
                mem.mem_wr = 1'b1;
                if (accept && last_word) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (clear) next_state = IDLE;
    end

    // Address and data follow grp/channel, which only move on accept, so both hold under waitrequest.
    assign mem.mem_addr = ADDR_WIDTH'(channel) * GROUPS_A + ADDR_WIDTH'(grp);

    ofm_row_packer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OUT_SIZE      (OUT_SIZE),
        .ROWS_PER_WORD (ROWS_PER_WORD)
    ) u_packer (
        .ofm   (ofm_buf),
        .group (grp),
        .word  (mem.mem_writedata)
    );

    // A new map is only captured when idle; arrivals while busy are dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofm_buf    <= '0;
            grp        <= '0;
            channel    <= '0;
            layer_done <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            grp        <= '0;
            channel    <= '0;
            layer_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if (in_valid) begin
                if (state == IDLE) begin
                    ofm_buf <= in_ofm;
                    grp     <= '0;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (accept) begin
                if (last_word) begin
                    grp        <= '0;
                    channel    <= last_channel ? '0 : channel + 1'b1;
                    layer_done <= last_channel;
                end else begin
                    grp <= grp + 1'b1;
                end
            end
        end
    end

`ifdef OFM_WB_WRITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count  <= '0;
            stall_count <= '0;
        end else if (clear) begin
            word_count  <= '0;
            stall_count <= '0;
        end else begin
            if (accept && (word_count != '1)) word_count <= word_count + 32'd1;
            if (mem.mem_wr && mem.mem_waitrequest && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
